// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with sequential / branch / jump /
// return next-pc selection and an optional circular return-address stack.
// Optional feature macro: PC_SEQUENCER_RAS_EN (builds the RAS). Without it,
// pc_src=3 loads target, call is ignored, ras_empty=1 and ras_err=0.
module pc_sequencer #(
  parameter int WIDTH     = 16,
  parameter int INC       = 2,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             pc_enable,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_err
);

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_JMP = 2'd2;
  localparam logic [1:0] SRC_RET = 2'd3;

  logic [WIDTH-1:0] pc_q, pc_d, pc_seq, ret_pc;

  // Fall-through address; also the return address pushed by a call.
  assign pc_seq = pc_q + WIDTH'(INC);

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  // Circular stack: sp_q is the next free slot, top lives at sp_q-1.
  // When full, the next free slot is the oldest entry, so a push there
  // overwrites the oldest return address.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    sp_q, sp_d, sp_inc, sp_dec, wr_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d, has_top, do_pop, wr_en;

  assign sp_inc  = (sp_q == LAST) ? '0 : sp_q + PW'(1);
  assign sp_dec  = (sp_q == '0) ? LAST : sp_q - PW'(1);
  assign has_top = (cnt_q != '0);
  assign do_pop  = (pc_src == SRC_RET) && has_top;
  assign ret_pc  = has_top ? ras_q[sp_dec] : pc_seq;

  // Stack pointer / count / error next state; call+return rewrites the top.
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    if (pc_enable) begin
      if ((pc_src == SRC_RET) && !has_top) err_d = 1'b1;
      if (call && do_pop) begin
        wr_en  = 1'b1;
        wr_idx = sp_dec;
      end else if (call) begin
        wr_en  = 1'b1;
        wr_idx = sp_q;
        sp_d   = sp_inc;
        if (cnt_q == FULL) err_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
      end else if (do_pop) begin
        sp_d  = sp_dec;
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Stack control state, cleared asynchronously.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage; contents are meaningless while count says empty.
  always_ff @(posedge CLK) begin
    if (wr_en) ras_q[wr_idx] <= pc_seq;
  end

  assign ras_empty = ~has_top;
  assign ras_err   = err_q;
`else
  logic unused_call;
  assign unused_call = call;
  assign ret_pc      = target;
  assign ras_empty   = 1'b1;
  assign ras_err     = 1'b0;
`endif

  // Next-pc select; holds when not enabled.
  always_comb begin
    pc_d = pc_q;
    if (pc_enable) begin
      case (pc_src)
        SRC_SEQ: pc_d = pc_seq;
        SRC_BR:  pc_d = pc_q + offset;
        SRC_JMP: pc_d = target;
        SRC_RET: pc_d = ret_pc;
        default: pc_d = pc_q;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) pc_q <= WIDTH'(RESET_PC);
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference model feeding an
// expected-pc scoreboard. Covers both builds via PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;
  localparam int W = 16;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         pc_enable = 1'b0;
  logic [1:0]   pc_src = 2'd0;
  logic [W-1:0] offset = '0;
  logic [W-1:0] target = '0;
  logic         call = 1'b0;
  logic [W-1:0] pc;
  logic         ras_empty, ras_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expq[$];
  logic [W-1:0] mstk[$];
  logic [W-1:0] mpc = '0;
  logic         merr = 1'b0;

  always #5 CLK = ~CLK;

  pc_sequencer #(.WIDTH(W), .INC(2), .RESET_PC(0), .RAS_DEPTH(D)) dut (
    .CLK(CLK), .reset(reset), .pc_enable(pc_enable), .pc_src(pc_src),
    .offset(offset), .target(target), .call(call), .pc(pc),
    .ras_empty(ras_empty), .ras_err(ras_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_empty();
`ifdef PC_SEQUENCER_RAS_EN
    return mstk.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  // Drive one edge, advance the model, queue expected pc, compare after edge.
  task automatic step(input logic en, input logic [1:0] src,
                      input logic [W-1:0] off, input logic [W-1:0] tgt,
                      input logic c);
    logic [W-1:0] seqv, n, e;
    pc_enable = en; pc_src = src; offset = off; target = tgt; call = c;
    if (en) begin
      seqv = mpc + 16'd2;
      n = mpc;
      case (src)
        2'd0: n = seqv;
        2'd1: n = mpc + off;
        2'd2: n = tgt;
        default: begin
`ifdef PC_SEQUENCER_RAS_EN
          if (mstk.size() > 0) n = mstk.pop_back();
          else begin n = seqv; merr = 1'b1; end
`else
          n = tgt;
`endif
        end
      endcase
`ifdef PC_SEQUENCER_RAS_EN
      if (c) begin
        if (mstk.size() == D) begin void'(mstk.pop_front()); merr = 1'b1; end
        mstk.push_back(seqv);
      end
`endif
      mpc = n;
    end
    expq.push_back(mpc);
    @(posedge CLK); #1;
    if (expq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      chk("pc", {16'd0, pc}, {16'd0, e});
    end
    chk("ras_empty", {31'd0, ras_empty}, {31'd0, exp_empty()});
    chk("ras_err", {31'd0, ras_err}, {31'd0, merr});
  endtask

  task automatic model_reset();
    mpc = '0; merr = 1'b0; mstk.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_pc", {16'd0, pc}, 32'h0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_err", {31'd0, ras_err}, 32'd0);
    reset = 1'b0;

    // Sequential 0 -> 2,4,6 then hold
    step(1, 2'd0, 16'h0, 16'h0, 0);
    step(1, 2'd0, 16'h0, 16'h0, 0);
    step(1, 2'd0, 16'h0, 16'h0, 0);
    chk("seq_pc6", {16'd0, pc}, 32'h6);
    step(0, 2'd2, 16'h0, 16'h1234, 1);
    step(0, 2'd3, 16'h0, 16'h1234, 1);
    chk("hold_pc6", {16'd0, pc}, 32'h6);

    // Negative branch and wrap
    step(1, 2'd2, 16'h0, 16'h0010, 0);
    step(1, 2'd1, 16'hFFF8, 16'h0, 0);
    chk("branch_neg", {16'd0, pc}, 32'h8);
    step(1, 2'd2, 16'h0, 16'hFFFE, 0);
    step(1, 2'd0, 16'h0, 16'h0, 0);
    chk("wrap", {16'd0, pc}, 32'h0);

    // Jump with call, then return
    step(1, 2'd2, 16'h0, 16'h0020, 0);
    step(1, 2'd2, 16'h0, 16'h0100, 1);
    chk("call_jump", {16'd0, pc}, 32'h100);
    step(1, 2'd3, 16'h0, 16'h0040, 0);
`ifdef PC_SEQUENCER_RAS_EN
    chk("return", {16'd0, pc}, 32'h22);
    // Five calls into a depth-4 stack, then five returns
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd0, 16'h0, 16'h0, 1);
      if (i == 3) chk("err_before_ovf", {31'd0, ras_err}, 32'd0);
    end
    chk("err_after_ovf", {31'd0, ras_err}, 32'd1);
    step(1, 2'd3, 16'h0, 16'h0, 0); chk("ret5", {16'd0, pc}, 32'h2C);
    step(1, 2'd3, 16'h0, 16'h0, 0); chk("ret4", {16'd0, pc}, 32'h2A);
    step(1, 2'd3, 16'h0, 16'h0, 0); chk("ret3", {16'd0, pc}, 32'h28);
    step(1, 2'd3, 16'h0, 16'h0, 0); chk("ret2", {16'd0, pc}, 32'h26);
    step(1, 2'd3, 16'h0, 16'h0, 0); chk("underflow", {16'd0, pc}, 32'h28);
    chk("err_sticky", {31'd0, ras_err}, 32'd1);
    // Call on empty stack with return, then call+return replacing the top
    step(1, 2'd3, 16'h0, 16'h0, 1);
    step(1, 2'd2, 16'h0, 16'h0300, 1);
    step(1, 2'd3, 16'h0, 16'h0, 1);
    step(1, 2'd3, 16'h0, 16'h0, 0);
    step(1, 2'd3, 16'h0, 16'h0, 0);
`else
    chk("ret_as_jump", {16'd0, pc}, 32'h40);
    chk("call_ignored", {31'd0, ras_empty}, 32'd1);
`endif

    // Asynchronous reset between edges during a call sequence
    step(1, 2'd2, 16'h0, 16'h0500, 1);
    step(1, 2'd0, 16'h0, 16'h0, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_pc", {16'd0, pc}, 32'h0);
    chk("async_empty", {31'd0, ras_empty}, 32'd1);
    chk("async_err", {31'd0, ras_err}, 32'd0);

    // Reset held across an enabled edge discards the update
    pc_enable = 1'b1; pc_src = 2'd2; target = 16'h1234; call = 1'b1;
    @(posedge CLK); #1;
    chk("rst_edge_pc", {16'd0, pc}, 32'h0);
    chk("rst_edge_empty", {31'd0, ras_empty}, 32'd1);
    #2 reset = 1'b0;
    step(1, 2'd0, 16'h0, 16'h0, 0);
    chk("first_after_rst", {16'd0, pc}, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
